// File: rtl/sync10011_tx.sv
// ---------------------------------------------------------------------------
// sync10011_tx
//
// Serial frame transmitter. Each accepted payload is sent one bit per clock
// as: sync pattern 1,0,0,1,1, then DATA_W payload bits MSB first, then an
// optional even-parity bit.
//
// Optional feature macro: SYNC10011_TX_PARITY_EN
//   defined   -> PAR state appends ^payload, frame is DATA_W+6 bits
//   undefined -> no parity logic, frame is DATA_W+5 bits
//
// Parameters
//   DATA_W      payload width in bits
//   IDLE_LEVEL  dout level while no frame is active
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset_n     asynchronous active-low reset
//   tx_valid    payload offered on tx_data
//   tx_data     payload, captured when tx_valid && tx_ready
//   tx_ready    block can accept a payload this cycle (state/counter only)
//   dout        serial line (registered)
//   dout_en     high while dout carries a frame bit (registered)
//   frame_done  one-cycle pulse with the last frame bit (registered)
// ---------------------------------------------------------------------------
module sync10011_tx #(
    parameter int   DATA_W     = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              dout,
    output logic              dout_en,
    output logic              frame_done
);

    // Counter must index 5 sync bits and DATA_W payload bits without wrapping.
    localparam int CNT_MAX = (DATA_W > 5) ? DATA_W : 5;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(4);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [4:0]       SYNC_PAT  = 5'b10011;  // bit 4 is sent first

`ifdef SYNC10011_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_t;
`endif

    // state_reg/cnt_reg always describe the bit currently on dout.
    state_t             state_reg,  state_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    logic [DATA_W-1:0]  shift_reg,  shift_next;
    logic               dout_next;
    logic               dout_en_next;
    logic               frame_done_next;
    logic               last_bit;
    logic               accept;
    logic [2:0]         sync_idx;

`ifdef SYNC10011_TX_PARITY_EN
    logic               parity_reg, parity_next;
`endif

    // Last-bit detection depends only on registered state, so tx_ready has
    // no path from any input.
`ifdef SYNC10011_TX_PARITY_EN
    assign last_bit = (state_reg == PAR);
`else
    assign last_bit = (state_reg == DATA) && (cnt_reg == DATA_LAST);
`endif

    assign tx_ready = (state_reg == IDLE) || last_bit;
    assign accept   = tx_valid && tx_ready;

    // Next-state, counter and shift register.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
`ifdef SYNC10011_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        if (accept) begin
            // Covers both IDLE and the last-bit cycle: back-to-back frames
            // go straight to SYNC with no gap.
            state_next = SYNC;
            cnt_next   = '0;
            shift_next = tx_data;
`ifdef SYNC10011_TX_PARITY_EN
            parity_next = ^tx_data;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = IDLE;
                end
                SYNC: begin
                    if (cnt_reg == SYNC_LAST) begin
                        state_next = DATA;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == DATA_LAST) begin
`ifdef SYNC10011_TX_PARITY_EN
                        state_next = PAR;
`else
                        state_next = IDLE;
`endif
                        cnt_next = '0;
                    end else begin
                        cnt_next   = cnt_reg + 1'b1;
                        shift_next = shift_reg << 1;
                    end
                end
`ifdef SYNC10011_TX_PARITY_EN
                PAR: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
`endif
                default: begin
                    // Unreachable encoding: recover to a clean idle.
                    state_next = IDLE;
                    cnt_next   = '0;
                    shift_next = '0;
                end
            endcase
        end
    end

    // Output values are derived from the next state so the output flops line
    // up with the state/counter registers in the same cycle.
    always_comb begin
        dout_next       = IDLE_LEVEL;
        dout_en_next    = 1'b0;
        frame_done_next = 1'b0;
        sync_idx        = 3'd4 - 3'(cnt_next);
        case (state_next)
            SYNC: begin
                dout_next    = SYNC_PAT[sync_idx];
                dout_en_next = 1'b1;
            end
            DATA: begin
                dout_next    = shift_next[DATA_W-1];
                dout_en_next = 1'b1;
`ifndef SYNC10011_TX_PARITY_EN
                frame_done_next = (cnt_next == DATA_LAST);
`endif
            end
`ifdef SYNC10011_TX_PARITY_EN
            PAR: begin
                dout_next       = parity_next;
                dout_en_next    = 1'b1;
                frame_done_next = 1'b1;
            end
`endif
            default: begin
                dout_next       = IDLE_LEVEL;
                dout_en_next    = 1'b0;
                frame_done_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            shift_reg  <= '0;
            dout       <= IDLE_LEVEL;
            dout_en    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            shift_reg  <= shift_next;
            dout       <= dout_next;
            dout_en    <= dout_en_next;
            frame_done <= frame_done_next;
        end
    end

`ifdef SYNC10011_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_reg <= 1'b0;
        end else begin
            parity_reg <= parity_next;
        end
    end
`endif

endmodule

// File: tb/tb_sync10011_tx.sv
// ---------------------------------------------------------------------------
// tb_sync10011_tx
//
// Scoreboard bench for sync10011_tx. On every acceptance the reference model
// expands the payload into its full list of frame bits (sync, payload MSB
// first, optional parity), each tagged with the cycle it must appear in, and
// queues them. A monitor on the falling edge pops and compares the head entry
// each cycle; cycles with nothing due must show an idle line.
// ---------------------------------------------------------------------------
module tb_sync10011_tx;

    localparam int   DATA_W     = 8;
    localparam logic IDLE_LEVEL = 1'b0;

    logic              clk;
    logic              reset_n;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              dout;
    logic              dout_en;
    logic              frame_done;

    sync10011_tx #(
        .DATA_W    (DATA_W),
        .IDLE_LEVEL(IDLE_LEVEL)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .dout      (dout),
        .dout_en   (dout_en),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic b;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    int   busy_until = 0;
    int   checks     = 0;
    int   failures   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Reference model: a frame is just a list of bits starting the cycle
    // after acceptance; the block is busy until its last bit is on the line.
    function automatic void push_frame(input int c, input logic [DATA_W-1:0] d);
        logic [4:0] sync_bits;
        logic       bits[$];
        exp_t       e;
        sync_bits = 5'b10011;
        for (int i = 4; i >= 0; i--) bits.push_back(sync_bits[i]);
        for (int i = DATA_W - 1; i >= 0; i--) bits.push_back(d[i]);
`ifdef SYNC10011_TX_PARITY_EN
        bits.push_back(^d);
`endif
        for (int k = 0; k < bits.size(); k++) begin
            e.cyc  = c + 1 + k;
            e.b    = bits[k];
            e.last = (k == bits.size() - 1);
            exp_q.push_back(e);
        end
        busy_until = c + bits.size();
    endfunction

    // Monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        logic model_ready;
        if (!reset_n) begin
            chk("rst_dout", dout, IDLE_LEVEL);
            chk("rst_dout_en", dout_en, 1'b0);
            chk("rst_frame_done", frame_done, 1'b0);
            chk("rst_tx_ready", tx_ready, 1'b1);
            exp_q.delete();
            busy_until = 0;
        end else begin
            model_ready = (cyc >= busy_until);
            chk("tx_ready", tx_ready, model_ready);
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("dout_en", dout_en, 1'b1);
                chk("dout", dout, e.b);
                chk("frame_done", frame_done, e.last);
                if (e.last) $display("frame_end cyc=%0d", cyc);
            end else begin
                chk("idle_dout_en", dout_en, 1'b0);
                chk("idle_dout", dout, IDLE_LEVEL);
                chk("idle_frame_done", frame_done, 1'b0);
            end
            if (tx_valid && model_ready) begin
                $display("accept cyc=%0d data=%02h", cyc, tx_data);
                push_frame(cyc, tx_data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a payload until it is taken (bounded), then drop tx_valid.
    task automatic send(input logic [DATA_W-1:0] d);
        int   n;
        logic rdy;
        n   = 0;
        rdy = 1'b0;
        tx_valid = 1'b1;
        tx_data  = d;
        do begin
            @(negedge clk);
            rdy = tx_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        checks++;
        if (!rdy) begin
            failures++;
            $display("FAIL send_timeout data=%02h actual=not_accepted required=accepted", d);
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        idle(3);
        reset_n = 1'b1;

        // Quiet line after reset.
        idle(20);

        // Single frame.
        send(8'hA5);
        idle(15);

        // Back-to-back frames with tx_valid held.
        send(8'hFF);
        send(8'h00);
        idle(15);

        // Input changes mid-frame must not disturb the frame.
        send(8'h3C);
        idle(2);
        tx_data = 8'hC3;
        idle(14);

        // Reset in the middle of a frame, then a fresh frame.
        send(8'h5A);
        idle(6);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        send(8'h81);
        idle(15);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = DATA_W'($urandom);
            reset_n  = ($urandom_range(0, 199) != 0);
            idle(1);
        end
        reset_n  = 1'b1;
        tx_valid = 1'b0;
        idle(DATA_W + 10);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
